melody_sequencer: RTL and testbench

Pattern sequencer that sits directly upstream of the musical tone generator. Holds a 16-step melody in a small register file, advances through it at a programmable tempo, and drives the tone generator's note select, octave select and tone enable inputs. Pattern is loaded over a simple write port while idle; playback is one-shot or looped.

---
 rtl/melody_sequencer.sv | 128 ++++++++++++
 tb/tb_melody_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// melody_sequencer: 16-step pattern player driving a tone generator.
// A small register file holds the melody; each step lasts a latched number of
// clocks, then advances, wraps (loop_en) or finishes with a done pulse.
// Optional feature: define MELODY_SEQ_GAP_EN to add an articulation gap
// (note_on low for the final GAP_CYCLES clocks of each sounding step).
module melody_sequencer #(
  parameter int STEPS      = 16,
  parameter int TEMPO_W    = 24,
  parameter int GAP_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [3:0]         wr_addr,
  input  logic [7:0]         wr_data,
  output logic               wr_ready,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
  input  logic [TEMPO_W-1:0] step_period,
  output logic [3:0]         note_sel,
  output logic [1:0]         octave_sel,
  output logic               note_on,
  output logic [3:0]         step_idx,
  output logic               step_strobe,
  output logic               busy,
  output logic               done
);

  localparam int AW = (STEPS > 1) ? $clog2(STEPS) : 1;

`ifdef MELODY_SEQ_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif

  localparam logic [TEMPO_W-1:0] GAP_LEN = TEMPO_W'(GAP_CYCLES);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t             state, state_nx;
  logic [7:0]         mem [STEPS];
  logic [TEMPO_W-1:0] cnt, limit;
  logic [AW-1:0]      idx, ld_idx;
  logic               cur_last, cur_sound;
  logic               final_cyc, wrap_cond;
  logic               load_step, go_idle, stop_idle, gap_enter;
  logic [7:0]         ld_word;

  assign busy      = (state != IDLE);
  assign step_idx  = 4'(idx);
  assign final_cyc = (cnt == limit - TEMPO_W'(1));
  assign wrap_cond = cur_last || (idx == AW'(STEPS - 1));
  assign ld_word   = mem[ld_idx];

  // Next-state and step-load decisions; stop beats start, start beats boundary.
  always_comb begin
    state_nx  = state;
    load_step = 1'b0;
    ld_idx    = '0;
    go_idle   = 1'b0;
    stop_idle = 1'b0;
    gap_enter = 1'b0;
    if (busy && stop) begin
      state_nx  = IDLE;
      stop_idle = 1'b1;
    end else if (start) begin
      state_nx  = PLAY;
      load_step = 1'b1;
    end else if (busy && final_cyc) begin
      if (wrap_cond && !loop_en) begin
        state_nx = IDLE;
        go_idle  = 1'b1;
      end else begin
        state_nx  = PLAY;
        load_step = 1'b1;
        ld_idx    = wrap_cond ? '0 : idx + 1'b1;
      end
    end else if (GAP_ON && state == PLAY && cur_sound && limit > GAP_LEN &&
                 cnt == limit - GAP_LEN - TEMPO_W'(1)) begin
      // Entering GAP here leaves exactly GAP_CYCLES cycles before the boundary.
      state_nx  = GAP;
      gap_enter = 1'b1;
    end
  end

  // State, pattern memory and registered tone-generator outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      for (int i = 0; i < STEPS; i++) mem[i] <= '0;
      cnt         <= '0;
      limit       <= TEMPO_W'(1);
      idx         <= '0;
      cur_last    <= 1'b0;
      cur_sound   <= 1'b0;
      note_sel    <= '0;
      octave_sel  <= '0;
      note_on     <= 1'b0;
      step_strobe <= 1'b0;
      done        <= 1'b0;
      wr_ready    <= 1'b1;
    end else begin
      if (wr_en && wr_ready) mem[wr_addr[AW-1:0]] <= wr_data;
      state       <= state_nx;
      step_strobe <= load_step;
      done        <= go_idle;
      // Stays low through the cycle busy falls, back high one cycle later.
      wr_ready    <= (state == IDLE) && (state_nx == IDLE);
      if (load_step) begin
        note_sel   <= ld_word[3:0];
        octave_sel <= ld_word[5:4];
        note_on    <= ld_word[6];
        cur_sound  <= ld_word[6];
        cur_last   <= ld_word[7];
        idx        <= ld_idx;
        cnt        <= '0;
        limit      <= (step_period == '0) ? TEMPO_W'(1) : step_period;
      end else if (busy) begin
        cnt <= cnt + TEMPO_W'(1);
      end
      if (go_idle || stop_idle || gap_enter) note_on <= 1'b0;
      if (stop_idle) idx <= '0;
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed self-checking bench for melody_sequencer.
module tb_melody_sequencer;

  logic        clk = 1'b0;
  logic        rst, wr_en, start, stop, loop_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [23:0] step_period;
  logic        wr_ready, note_on, step_strobe, busy, done;
  logic [3:0]  note_sel, step_idx;
  logic [1:0]  octave_sel;

  int n_chk  = 0;
  int n_fail = 0;

  melody_sequencer #(.STEPS(16), .TEMPO_W(24), .GAP_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .start(start), .stop(stop), .loop_en(loop_en),
    .step_period(step_period), .note_sel(note_sel), .octave_sel(octave_sel),
    .note_on(note_on), .step_idx(step_idx), .step_strobe(step_strobe),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  logic [3:0] exp_note [3];
  logic [1:0] exp_oct  [3];
  logic       exp_on   [3];

  initial begin
    exp_note = '{4'h0, 4'h9, 4'h7};
    exp_oct  = '{2'd0, 2'd1, 2'd0};
    exp_on   = '{1'b1, 1'b0, 1'b1};
    rst = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0; start = 0; stop = 0;
    loop_en = 0; step_period = 24'd10;
    ticks(2);
    rst = 1'b0;

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_note_on", note_on, 0);
    chk("rst_idx", step_idx, 0);
    chk("rst_strobe", step_strobe, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_note", note_sel, 0);

    wr(4'd0, 8'h40);
    wr(4'd1, 8'h19);
    wr(4'd2, 8'hC7);

    // One-shot, period 10: steps at cycles 1, 11, 21, done at 31
    start = 1; tick(); start = 0;
    chk("os_busy", busy, 1);
    chk("os_wr_ready", wr_ready, 0);
    for (int k = 0; k < 3; k++) begin
      chk("os_strobe", step_strobe, 1);
      chk("os_idx", step_idx, k);
      chk("os_note", note_sel, exp_note[k]);
      chk("os_oct", octave_sel, exp_oct[k]);
      chk("os_on", note_on, exp_on[k]);
      ticks(9);
      chk("os_mid_strobe", step_strobe, 0);
      chk("os_mid_idx", step_idx, k);
      chk("os_mid_done", done, 0);
      tick();
    end
    chk("os_done", done, 1);
    chk("os_end_busy", busy, 0);
    chk("os_end_on", note_on, 0);
    chk("os_end_wr_ready", wr_ready, 0);
    chk("os_hold_note", note_sel, 4'h7);
    tick();
    chk("os_done_pulse", done, 0);
    chk("os_wr_ready_back", wr_ready, 1);

    // Looping, with a dropped write while busy
    loop_en = 1; start = 1; tick(); start = 0;
    for (int l = 0; l < 3; l++) begin
      for (int k = 0; k < 3; k++) begin
        chk("loop_strobe", step_strobe, 1);
        chk("loop_idx", step_idx, k);
        chk("loop_note", note_sel, exp_note[k]);
        chk("loop_done", done, 0);
        if (l == 0 && k == 1) begin
          wr_en = 1; wr_addr = 0; wr_data = 8'h4F; tick(); wr_en = 0;
          ticks(8);
        end else begin
          ticks(9);
        end
        chk("loop_gap_strobe", step_strobe, 0);
        tick();
      end
    end
    // Loop 4 step 0 at strobe; move into step 1 then stop+start together
    chk("loop4_idx", step_idx, 0);
    ticks(13);
    chk("mid1_idx", step_idx, 1);
    chk("mid1_busy", busy, 1);
    stop = 1; start = 1; tick(); stop = 0; start = 0;
    chk("stop_busy", busy, 0);
    chk("stop_on", note_on, 0);
    chk("stop_idx", step_idx, 0);
    chk("stop_done", done, 0);
    chk("stop_strobe", step_strobe, 0);
    tick();
    chk("stop_done2", done, 0);
    chk("stop_busy2", busy, 0);

    // Period 0 treated as 1: strobe every cycle
    loop_en = 0; step_period = 24'd0;
    start = 1; tick(); start = 0;
    for (int k = 0; k < 3; k++) begin
      chk("p0_strobe", step_strobe, 1);
      chk("p0_idx", step_idx, k);
      chk("p0_on", note_on, exp_on[k]);
      tick();
    end
    chk("p0_done", done, 1);
    chk("p0_busy", busy, 0);
    chk("p0_strobe_off", step_strobe, 0);

`ifdef MELODY_SEQ_GAP_EN
    // Gap: period 10, GAP_CYCLES 3 -> 7 high, 3 low per sounding step
    step_period = 24'd10;
    start = 1; tick(); start = 0;
    chk("gap_on_c1", note_on, 1);
    ticks(6);
    chk("gap_on_c7", note_on, 1);
    tick();
    chk("gap_off_c8", note_on, 0);
    chk("gap_busy_c8", busy, 1);
    ticks(2);
    chk("gap_off_c10", note_on, 0);
    tick();
    chk("gap_step1_strobe", step_strobe, 1);
    chk("gap_step1_idx", step_idx, 1);
    stop = 1; tick(); stop = 0;
    // Period 3: limit not above GAP_CYCLES, no gap
    step_period = 24'd3;
    start = 1; tick(); start = 0;
    chk("nogap_c1", note_on, 1);
    ticks(2);
    chk("nogap_c3", note_on, 1);
    stop = 1; tick(); stop = 0;
`endif

    // Reset mid-playback clears the pattern
    loop_en = 1; step_period = 24'd10;
    start = 1; tick(); start = 0;
    ticks(5);
    rst = 1; tick(); rst = 0;
    chk("mrst_busy", busy, 0);
    chk("mrst_on", note_on, 0);
    chk("mrst_note", note_sel, 0);
    chk("mrst_oct", octave_sel, 0);
    chk("mrst_wr_ready", wr_ready, 1);
    // Cleared pattern: all rests, no last flag, runs to step 15
    loop_en = 0; step_period = 24'd1;
    start = 1; tick(); start = 0;
    chk("clr_idx0", step_idx, 0);
    chk("clr_on0", note_on, 0);
    chk("clr_note0", note_sel, 0);
    ticks(15);
    chk("clr_idx15", step_idx, 15);
    chk("clr_busy15", busy, 1);
    tick();
    chk("clr_done", done, 1);
    chk("clr_busy_end", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
